// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop stream bundle between a FIFO user (master) and sram_fifo_ctrl (slave).
// Carries both valid/ready handshakes plus the occupancy count.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO on a 1W/1R SRAM macro with a 2-entry prefetch buffer; push-to-out_valid 3 edges, 1 word/cycle sustained.
// Backpressure: in_ready drops when the macro holds RAM_DEPTH words; out_data holds while out_ready is low.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  sram_fifo_ctrl_if.slave       bus,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] obuf [2];
  logic                  ob_head;
  logic                  ob_tail;
  logic [1:0]            ob_cnt;

  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic [2:0]            ob_occ;

  assign bus.in_ready  = rstb && (mem_cnt < MEM_FULL);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (ob_cnt != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = obuf[ob_head];

  // A read in flight already owns an obuf slot, so it counts toward occupancy.
  assign ob_occ   = {1'b0, ob_cnt} + {2'b00, rd_pend};
  assign rd_issue = rstb && (mem_cnt != '0) && (ob_occ < (3'd2 + {2'b00, pop}));

  assign csb0  = !push;
  assign web0  = !push;
  assign addr0 = wptr;
  assign din0  = bus.in_data;
  assign csb1  = !rd_issue;
  assign addr1 = rptr;

  assign bus.count = mem_cnt + (ADDR_WIDTH+1)'(rd_pend) + (ADDR_WIDTH+1)'(ob_cnt);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
      ob_head <= 1'b0;
      ob_tail <= 1'b0;
      ob_cnt  <= 2'd0;
      obuf[0] <= '0;
      obuf[1] <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (rd_issue) begin
        rptr <= rptr + ADDR_WIDTH'(1);
      end
      rd_pend <= rd_issue;
      mem_cnt <= mem_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(rd_issue);
      // dout1 settles after the negedge, so the word read last cycle is valid here.
      if (rd_pend) begin
        obuf[ob_tail] <= dout1;
        ob_tail       <= ~ob_tail;
      end
      if (pop) begin
        ob_head <= ~ob_head;
      end
      ob_cnt <= ob_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  a_no_port_collision: assert property (@(posedge clk) disable iff (!rstb)
    !(push && rd_issue && (wptr == rptr)));

  a_no_obuf_overflow: assert property (@(posedge clk) disable iff (!rstb)
    !(rd_pend && !pop && (ob_cnt == 2'd2)));
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl against a behavioural 1W/1R macro model.
module tb_sram_fifo_ctrl;
  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk  = 1'b0;
  logic          rstb = 1'b1;
  logic          csb0, web0, csb1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout1 = '0;

  int checks   = 0;
  int failures = 0;
  int coll_cnt = 0;
  logic [DW-1:0] exp_q [$];

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .bus   (bus),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .csb1  (csb1),
    .addr1 (addr1),
    .dout1 (dout1)
  );

  always #5 clk = ~clk;

  // Macro model: inputs registered at posedge, write at negedge, read data at negedge + 1.
  logic [DW-1:0] mem [DEPTH];
  logic          m_cs0 = 1'b1, m_we0 = 1'b1, m_cs1 = 1'b1;
  logic [AW-1:0] m_a0 = '0, m_a1 = '0;
  logic [DW-1:0] m_d0 = '0;

  always @(posedge clk) begin
    m_cs0 <= csb0;
    m_we0 <= web0;
    m_a0  <= addr0;
    m_d0  <= din0;
    m_cs1 <= csb1;
    m_a1  <= addr1;
    if (!csb0 && !csb1 && (addr0 == addr1)) coll_cnt <= coll_cnt + 1;
  end

  always @(negedge clk) begin
    if (!m_cs0 && !m_we0) mem[m_a0] = m_d0;
    if (!m_cs1) begin
      #1;
      dout1 = mem[m_a1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 2'b11;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.count} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got in_ready=%b out_valid=%b count=%0d exp 0/0/0",
               bus.in_ready, bus.out_valid, bus.count);
    end
    checks++;
    if ({csb0, web0, csb1, addr0, addr1, bus.out_data} !== {3'b111, 10'b0}) begin
      failures++;
      $display("FAIL reset_macro got csb0=%b web0=%b csb1=%b addr0=%0d addr1=%0d out_data=%0d exp 1/1/1/0/0/0",
               csb0, web0, csb1, addr0, addr1, bus.out_data);
    end
    bus.in_valid = 1'b0;
    rstb = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b10;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, csb0, web0, addr0, din0} !== {3'b100, 4'd0, 2'b10}) begin
      failures++;
      $display("FAIL single_write got in_ready=%b csb0=%b web0=%b addr0=%0d din0=%0d exp 1/0/0/0/2",
               bus.in_ready, csb0, web0, addr0, din0);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({csb1, addr1, bus.out_valid} !== {1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL single_read_issue got csb1=%b addr1=%0d out_valid=%b exp 0/0/0",
               csb1, addr1, bus.out_valid);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.count} !== {1'b0, 5'd1}) begin
      failures++;
      $display("FAIL single_inflight got out_valid=%b count=%0d exp 0/1", bus.out_valid, bus.count);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.count} !== {1'b1, 2'b10, 5'd1}) begin
      failures++;
      $display("FAIL single_out got out_valid=%b out_data=%0d count=%0d exp 1/2/1",
               bus.out_valid, bus.out_data, bus.count);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.count} !== {1'b0, 5'd0}) begin
      failures++;
      $display("FAIL single_pop got out_valid=%b count=%0d exp 0/0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_fill();
    int acc;
    int popped;
    acc = 0;
    popped = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(acc % 4);
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        acc++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc != DEPTH + 2) begin
      failures++;
      $display("FAIL fill_accepted got %0d exp %0d", acc, DEPTH + 2);
    end
    checks++;
    if ({bus.in_ready, bus.count} !== {1'b0, 5'd18}) begin
      failures++;
      $display("FAIL fill_full got in_ready=%b count=%0d exp 0/18", bus.in_ready, bus.count);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== exp_q[0]) begin
          failures++;
          $display("FAIL fill_drain_data word=%0d got %0d exp %0d", popped, bus.out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        popped++;
      end
      tick();
      if (popped == 1 && bus.out_valid) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL fill_ready_after_pop got %b exp 1", bus.in_ready);
        end
      end
    end
    bus.out_ready = 1'b0;
    checks++;
    if (popped != DEPTH + 2 || bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain_end got popped=%0d count=%0d out_valid=%b exp 18/0/0",
               popped, bus.count, bus.out_valid);
    end
    exp_q.delete();
    checks++;
    if (coll_cnt != 0) begin
      failures++;
      $display("FAIL fill_collision got %0d exp 0", coll_cnt);
    end
  endtask

  task automatic test_stream();
    int pushed;
    int popped;
    bit started;
    pushed = 0;
    popped = 0;
    started = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && popped < 40; c++) begin
      bus.in_valid = (pushed < 40);
      bus.in_data  = DW'((pushed * 3 + 1) % 4);
      @(negedge clk);
      if (bus.out_valid) started = 1'b1;
      if (started && bus.in_valid) begin
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.count} !== {2'b11, 5'd3}) begin
          failures++;
          $display("FAIL stream_steady cycle=%0d got out_valid=%b in_ready=%b count=%0d exp 1/1/3",
                   c, bus.out_valid, bus.in_ready, bus.count);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        pushed++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
          failures++;
          $display("FAIL stream_data word=%0d got %0d exp %0d", popped, bus.out_data,
                   (exp_q.size() == 0) ? 0 : int'(exp_q[0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (popped != 40 || bus.count !== 5'd0 || coll_cnt != 0) begin
      failures++;
      $display("FAIL stream_end got popped=%0d count=%0d collisions=%0d exp 40/0/0",
               popped, bus.count, coll_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int pushed;
    int popped;
    bit stalled;
    logic [DW-1:0] held;
    pushed = 0;
    popped = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 400 && popped < 30; c++) begin
      bus.in_valid  = (pushed < 30);
      bus.in_data   = DW'((pushed + pushed / 4) % 4);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
          failures++;
          $display("FAIL bp_hold cycle=%0d got out_valid=%b out_data=%0d exp 1/%0d",
                   c, bus.out_valid, bus.out_data, held);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        pushed++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
          failures++;
          $display("FAIL bp_data word=%0d got %0d exp %0d", popped, bus.out_data,
                   (exp_q.size() == 0) ? 0 : int'(exp_q[0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (popped != 30 || bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end got popped=%0d count=%0d out_valid=%b exp 30/0/0",
               popped, bus.count, bus.out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int pushed;
    pushed = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20 && pushed < 7; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(pushed % 4);
      @(negedge clk);
      if (bus.in_ready) pushed++;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.count !== 5'd7) begin
      failures++;
      $display("FAIL mid_pre_count got %0d exp 7", bus.count);
    end
    // Push and pop together with a full obuf: a read issues, leaving one in flight.
    bus.in_valid  = 1'b1;
    bus.in_data   = 2'b11;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, csb1} !== 3'b110) begin
      failures++;
      $display("FAIL mid_pre_issue got out_valid=%b in_ready=%b csb1=%b exp 1/1/0",
               bus.out_valid, bus.in_ready, csb1);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 5'd7) begin
      failures++;
      $display("FAIL mid_pend_count got %0d exp 7", bus.count);
    end
    rstb = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.count} !== 9'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got in_ready=%b out_valid=%b out_data=%0d count=%0d exp 0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.count);
    end
    checks++;
    if ({csb0, web0, csb1, addr0, addr1} !== {3'b111, 8'b0}) begin
      failures++;
      $display("FAIL mid_reset_macro got csb0=%b web0=%b csb1=%b addr0=%0d addr1=%0d exp 1/1/1/0/0",
               csb0, web0, csb1, addr0, addr1);
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rstb = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b01;
    @(negedge clk);
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10 && !bus.out_valid; c++) tick();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.count} !== {1'b1, 2'b01, 5'd1}) begin
      failures++;
      $display("FAIL mid_first_word got out_valid=%b out_data=%0d count=%0d exp 1/1/1",
               bus.out_valid, bus.out_data, bus.count);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.count} !== {1'b0, 5'd0}) begin
      failures++;
      $display("FAIL mid_final_pop got out_valid=%b count=%0d exp 0/0", bus.out_valid, bus.count);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
